// File: rtl/spi_flash_read_master.sv
// SPI mode-0 READ (0x03) initiator: sends command+address, shifts in DATA_BYTES bytes, returns them little-endian.
// rsp_valid lands NBITS*2*CLK_DIV clocks after accept; rsp held until rsp_ready, no new request until deselect done.
module spi_flash_read_master #(
    parameter int CLK_DIV    = 2,
    parameter int ADDR_BITS  = 24,
    parameter int DATA_BYTES = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_BITS-1:0]      req_addr,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [8*DATA_BYTES-1:0]   rsp_data,
    output logic                      busy,
    output logic                      flash_csb,
    output logic                      flash_clk,
    output logic                      flash_io0,
    input  logic                      flash_io1
);

    localparam int CMD_BITS = 8 + ADDR_BITS;
    localparam int DW       = 8 * DATA_BYTES;
    localparam int NBITS    = CMD_BITS + DW;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W    = $clog2(NBITS);
    localparam int DSEL_W   = $clog2(2 * CLK_DIV);

    localparam logic [7:0]        CMD_READ  = 8'h03;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(NBITS - 1);
    localparam logic [DSEL_W-1:0] DSEL_LAST = DSEL_W'(2 * CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_RESP
    } state_e;

    state_e                state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic                  sck_hi_q, sck_hi_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [CMD_BITS-2:0]   sout_q, sout_d;
    logic [DW-2:0]         sin_q, sin_d;
    logic                  csb_q, csb_d;
    logic                  clk_q, clk_d;
    logic                  io0_q, io0_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]         rsp_data_q, rsp_data_d;
    logic [DSEL_W-1:0]     dsel_q, dsel_d;
    logic                  acked_q, acked_d;

    logic [DW-1:0]         sin_next;
    logic [DW-1:0]         rsp_swap;
    logic                  rsp_hs;

    // Bits arrive MSB-first and first-byte-first; reorder so byte k sits at [8k+7:8k].
    always_comb begin
        sin_next = {sin_q, flash_io1};
        rsp_swap = '0;
        for (int k = 0; k < DATA_BYTES; k++) begin
            rsp_swap[8*k +: 8] = sin_next[DW-1-8*k -: 8];
        end
    end

    assign rsp_hs = rsp_valid_q && rsp_ready;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        sck_hi_d    = sck_hi_q;
        bit_d       = bit_q;
        sout_d      = sout_q;
        sin_d       = sin_q;
        csb_d       = csb_q;
        clk_d       = clk_q;
        io0_d       = io0_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        dsel_d      = dsel_q;
        acked_d     = acked_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d  = ST_SHIFT;
                    sout_d   = {CMD_READ[6:0], req_addr};
                    io0_d    = CMD_READ[7];
                    csb_d    = 1'b0;
                    clk_d    = 1'b0;
                    div_d    = '0;
                    sck_hi_d = 1'b0;
                    bit_d    = '0;
                    acked_d  = 1'b0;
                end
            end

            ST_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sck_hi_q) begin
                        sck_hi_d = 1'b1;
                        clk_d    = 1'b1;
                    end else begin
                        // Last clock of SCK high: capture MISO, then fall and advance the slot.
                        sck_hi_d = 1'b0;
                        clk_d    = 1'b0;
                        sin_d    = sin_next[DW-2:0];
                        if (bit_q == BIT_LAST) begin
                            state_d     = ST_RESP;
                            csb_d       = 1'b1;
                            io0_d       = 1'b0;
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = rsp_swap;
                            dsel_d      = '0;
                        end else begin
                            bit_d  = bit_q + 1'b1;
                            io0_d  = sout_q[CMD_BITS-2];
                            sout_d = {sout_q[CMD_BITS-3:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            ST_RESP: begin
                if (rsp_hs) begin
                    rsp_valid_d = 1'b0;
                    acked_d     = 1'b1;
                end
                if (dsel_q != DSEL_LAST) begin
                    dsel_d = dsel_q + 1'b1;
                end
                // Leave only once both the response is taken and csb has been high long enough.
                if ((dsel_q == DSEL_LAST) && (acked_q || rsp_hs)) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            sck_hi_q    <= 1'b0;
            bit_q       <= '0;
            sout_q      <= '0;
            sin_q       <= '0;
            csb_q       <= 1'b1;
            clk_q       <= 1'b0;
            io0_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            dsel_q      <= '0;
            acked_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            sck_hi_q    <= sck_hi_d;
            bit_q       <= bit_d;
            sout_q      <= sout_d;
            sin_q       <= sin_d;
            csb_q       <= csb_d;
            clk_q       <= clk_d;
            io0_q       <= io0_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            dsel_q      <= dsel_d;
            acked_q     <= acked_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign flash_csb = csb_q;
    assign flash_clk = clk_q;
    assign flash_io0 = io0_q;

endmodule
